// File: rtl/mainfsm_pkg.sv
// Shared encodings for the multicycle main controller: state codes, datapath
// mux selects, instruction classes and the control bundle.
package mainfsm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } statetype;

    localparam logic [1:0] SRCA_RN       = 2'b00;
    localparam logic [1:0] SRCA_PC       = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT   = 2'b10;

    localparam logic [1:0] SRCB_RM       = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UNK = 2'b11;

    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/mainfsm_outdec.sv
// Moore output decode: maps the current state to the raw control bundle.
// Unlisted and illegal states drive everything low.
module mainfsm_outdec
    import mainfsm_pkg::*;
(
    input  statetype state,
    output ctrl_t    ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.adrsrc    = 1'b0;
                ctrl.alusrca   = SRCA_PC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.resultsrc = RES_ALURESULT;
                ctrl.irwrite   = 1'b1;
                ctrl.nextpc    = 1'b1;
            end
            DECODE: begin
                ctrl.alusrca   = SRCA_PC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.resultsrc = RES_ALURESULT;
            end
            MEMADR: begin
                ctrl.alusrca = SRCA_RN;
                ctrl.alusrcb = SRCB_IMM;
            end
            MEMREAD: begin
                ctrl.adrsrc    = 1'b1;
                ctrl.resultsrc = RES_ALUOUT;
            end
            MEMWB: begin
                ctrl.resultsrc = RES_DATA;
                ctrl.regw      = 1'b1;
            end
            MEMWRITE: begin
                ctrl.adrsrc    = 1'b1;
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.memw      = 1'b1;
            end
            EXECUTER: begin
                ctrl.alusrca = SRCA_RN;
                ctrl.alusrcb = SRCB_RM;
                ctrl.aluop   = 1'b1;
            end
            EXECUTEI: begin
                ctrl.alusrca = SRCA_RN;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = 1'b1;
            end
            ALUWB: begin
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.regw      = 1'b1;
            end
            BRANCH: begin
                ctrl.alusrca   = SRCA_ALUOUT;
                ctrl.alusrcb   = SRCB_IMM;
                ctrl.resultsrc = RES_ALURESULT;
                ctrl.branch    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mainfsm.sv
// Multicycle main controller: state register, next-state logic and strobe gating.
// Define MAINFSM_MEMWAIT_EN to add the MemReady wait-state handshake.
module mainfsm
    import mainfsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
`ifdef MAINFSM_MEMWAIT_EN
    input  logic       MemReady,
`endif
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic [3:0] State
);

    statetype state;
    ctrl_t    ctrl;
    logic     rdy;
    logic     unused_funct;

`ifdef MAINFSM_MEMWAIT_EN
    assign rdy = MemReady;
`else
    assign rdy = 1'b1;
`endif

    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    state <= rdy ? DECODE : FETCH;
                DECODE: begin
                    case (Op)
                        OP_MEM:  state <= MEMADR;
                        OP_DP:   state <= Funct[5] ? EXECUTEI : EXECUTER;
                        OP_BR:   state <= BRANCH;
                        default: state <= UNKNOWN;
                    endcase
                end
                MEMADR:   state <= Funct[0] ? MEMREAD : MEMWRITE;
                MEMREAD:  state <= rdy ? MEMWB : MEMREAD;
                MEMWB:    state <= FETCH;
                MEMWRITE: state <= rdy ? FETCH : MEMWRITE;
                EXECUTER: state <= ALUWB;
                EXECUTEI: state <= ALUWB;
                default:  state <= FETCH;
            endcase
        end
    end

    mainfsm_outdec u_outdec (
        .state (state),
        .ctrl  (ctrl)
    );

    // Reset holds the state at FETCH, so only the strobes need explicit gating.
    assign IRWrite   = reset & ctrl.irwrite & rdy;
    assign NextPC    = reset & ctrl.nextpc & rdy;
    assign RegW      = reset & ctrl.regw;
    assign MemW      = reset & ctrl.memw;
    assign Branch    = reset & ctrl.branch;
    assign AdrSrc    = ctrl.adrsrc;
    assign ALUSrcA   = ctrl.alusrca;
    assign ALUSrcB   = ctrl.alusrcb;
    assign ResultSrc = ctrl.resultsrc;
    assign ALUOp     = ctrl.aluop;
    assign State     = state;

endmodule

// File: tb/tb_mainfsm.sv
// Randomized check of mainfsm against an instruction-level sequence model,
// plus the directed reset-abort and (with MAINFSM_MEMWAIT_EN) stall scenarios.
module tb_mainfsm;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3,
                   S_MEMWB = 4, S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7,
                   S_ALUWB = 8, S_BRANCH = 9, S_UNKNOWN = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic       MemReady = 1'b1;
    logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] State;
    logic [12:0] obs;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    mainfsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
`ifdef MAINFSM_MEMWAIT_EN
        .MemReady  (MemReady),
`endif
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .State     (State)
    );

    assign obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output table: {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch}
    function automatic logic [12:0] exp_out(input int s, input logic rdy);
        case (s)
            S_FETCH:    return {rdy, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, rdy, 3'b000};
            S_DECODE:   return {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 3'b000};
            S_MEMADR:   return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 3'b000};
            S_MEMREAD:  return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000};
            S_MEMWB:    return {1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 3'b100};
            S_MEMWRITE: return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b010};
            S_EXECR:    return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 3'b000};
            S_EXECI:    return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 3'b000};
            S_ALUWB:    return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b100};
            S_BRANCH:   return {1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 3'b001};
            default:    return 13'd0;
        endcase
    endfunction

    function automatic bit can_stall(input int s);
`ifdef MAINFSM_MEMWAIT_EN
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
`else
        return (s < 0);
`endif
    endfunction

    // Called at posedge+1 with the DUT in FETCH; runs one whole instruction.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input bit rnd_rdy);
        int seq[$];
        int cycles = 0, regw_n = 0, memw_n = 0, lat, iter = 0;
        bit is_load, is_store, is_dp;
        is_load  = (op == 2'b01) && funct[0];
        is_store = (op == 2'b01) && !funct[0];
        is_dp    = (op == 2'b00);
        lat = is_load ? 5 : (is_store || is_dp) ? 4 : 3;
        seq.push_back(S_FETCH);
        seq.push_back(S_DECODE);
        case (op)
            2'b01: begin
                seq.push_back(S_MEMADR);
                if (funct[0]) begin seq.push_back(S_MEMREAD); seq.push_back(S_MEMWB); end
                else seq.push_back(S_MEMWRITE);
            end
            2'b00: begin
                seq.push_back(funct[5] ? S_EXECI : S_EXECR);
                seq.push_back(S_ALUWB);
            end
            2'b10:   seq.push_back(S_BRANCH);
            default: seq.push_back(S_UNKNOWN);
        endcase
        Op = op;
        Funct = funct;
        while (seq.size() > 0) begin
            if (iter++ > 200) begin
                chk("timeout", 1, 0);
                break;
            end
`ifdef MAINFSM_MEMWAIT_EN
            MemReady = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
`else
            MemReady = rnd_rdy | 1'b1;
`endif
            @(negedge clk);
            chk($sformatf("state op=%0d f=%0h", op, funct), State, seq[0]);
            chk($sformatf("ctrl s=%0d", seq[0]), obs, exp_out(seq[0], MemReady));
            regw_n += RegW;
            if (MemReady || !can_stall(seq[0])) memw_n += MemW;
            @(posedge clk);
            #1;
            if (!(can_stall(seq[0]) && !MemReady)) begin
                void'(seq.pop_front());
                cycles++;
            end
        end
        chk("latency", cycles, lat);
        chk("regw_count", regw_n, is_load || is_dp);
        chk("memw_count", memw_n, is_store);
    endtask

    initial begin
        // Reset: FETCH asynchronously, strobes low, mux selects at FETCH values.
        #2;
        chk("rst_state", State, S_FETCH);
        chk("rst_ctrl", obs, exp_out(S_FETCH, 1'b0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold", State, S_FETCH);
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_instr(2'b00, 6'b000000, 1'b0);
        run_instr(2'b01, 6'b000001, 1'b0);
        run_instr(2'b01, 6'b000000, 1'b0);
        run_instr(2'b10, 6'b000000, 1'b0);
        run_instr(2'b11, 6'b000000, 1'b0);
        run_instr(2'b00, 6'b100000, 1'b0);

        // Abort a store in MEMWRITE with an asynchronous reset.
        Op = 2'b01;
        Funct = 6'd0;
        MemReady = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_pre_state", State, S_MEMWRITE);
        chk("abort_pre_memw", MemW, 1);
        #1 reset = 1'b0;
        #1;
        chk("abort_state", State, S_FETCH);
        chk("abort_memw", MemW, 0);
        chk("abort_ctrl", obs, exp_out(S_FETCH, 1'b0));
        repeat (3) begin
            @(negedge clk);
            chk("abort_hold_state", State, S_FETCH);
            chk("abort_hold_ctrl", obs, exp_out(S_FETCH, 1'b0));
        end
        @(posedge clk);
        #1 reset = 1'b1;
        run_instr(2'b00, 6'b000000, 1'b0);

`ifdef MAINFSM_MEMWAIT_EN
        // Three-cycle fetch stall, then a branch.
        Op = 2'b10;
        MemReady = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_state", State, S_FETCH);
            chk("stall_irwrite", IRWrite, 0);
            @(posedge clk);
            #1;
        end
        MemReady = 1'b1;
        @(negedge clk);
        chk("stall_rel_irwrite", IRWrite, 1);
        @(posedge clk);
        @(negedge clk);
        chk("stall_decode", State, S_DECODE);
        chk("stall_dec_irwrite", IRWrite, 0);
        @(posedge clk);
        @(negedge clk);
        chk("stall_branch", State, S_BRANCH);
        @(posedge clk);
        #1;
`endif

        for (int i = 0; i < 150; i++) begin
            run_instr(2'($urandom_range(0, 3)), 6'($urandom), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mainfsm.md
MAINFSM -- requirements
Module: mainfsm

Interface
- REQ-001: mainfsm SHALL have these ports, clock and reset first:
  - clk  input  1  — single clock; all state changes on the rising edge.
  - reset  input  1  — asynchronous, active-low reset.
  - Op  input  2  — instruction class from the decoder.
  - Funct  input  6  — instruction Funct field; bit 5 = I, bit 0 = L/S.
  - MemReady  input  1  — memory completion handshake; present only with MAINFSM_MEMWAIT_EN.
  - IRWrite  output  1  — instruction register load strobe.
  - AdrSrc  output  1  — memory address select: 0 = PC, 1 = ALU result.
  - ALUSrcA  output  2  — ALU A select: 00 = Rn, 01 = PC, 10 = ALUOut.
  - ALUSrcB  output  2  — ALU B select: 00 = Rm, 01 = immediate, 10 = constant 4.
  - ResultSrc  output  2  — result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
  - ALUOp  output  1  — 1 = decoder applies Funct-derived ALU control.
  - NextPC  output  1  — PC advance request to condlogic.
  - RegW  output  1  — register write request, qualified downstream by CondEx.
  - MemW  output  1  — memory write request, qualified downstream by CondEx.
  - Branch  output  1  — branch request; decoder forms PCS from it.
  - State  output  4  — current state encoding, for debug.

Function
- REQ-002: mainfsm SHALL be a Moore FSM; every output SHALL be a function of the current state only, except the REQ-014 gating.
- REQ-003: States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN.
- REQ-004: FETCH SHALL go to DECODE.
- REQ-005: DECODE SHALL branch on Op and Funct:
  - Op=01 → MEMADR.
  - Op=00 and Funct[5]=0 → EXECUTER.
  - Op=00 and Funct[5]=1 → EXECUTEI.
  - Op=10 → BRANCH.
  - Op=11 → UNKNOWN.
- REQ-006: MEMADR SHALL go to MEMREAD when Funct[0]=1, else to MEMWRITE.
- REQ-007: The remaining transitions SHALL be:
  - MEMREAD → MEMWB → FETCH.
  - MEMWRITE → FETCH.
  - EXECUTER → ALUWB; EXECUTEI → ALUWB; ALUWB → FETCH.
  - BRANCH → FETCH.
  - UNKNOWN → FETCH.
- REQ-008: Outputs per state SHALL be as listed; any output not listed for a state is 0:
  - FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.
  - UNKNOWN: all outputs 0.
- REQ-009: Instruction latency SHALL be: load 5 cycles, store 4, data-processing 4, branch 3, unknown 3 (all without wait states).
- REQ-010: Any illegal State encoding SHALL go to FETCH on the next edge and drive all outputs 0.
- REQ-011: RegW and MemW SHALL each be high for exactly one cycle per instruction, ignoring wait states.

Reset
- REQ-012: While reset=0, State SHALL be FETCH, asynchronously and independent of clk.
- REQ-013: The first rising clk edge after reset rises SHALL move the FSM to DECODE, or hold FETCH under REQ-016.
- REQ-014: While reset=0, IRWrite, NextPC, RegW, MemW and Branch SHALL be forced to 0; the mux selects SHALL take their FETCH values.
- REQ-015: Reset asserted mid-instruction SHALL abandon the instruction; no write strobe SHALL be asserted during or after the abort.

Configuration
- REQ-016: With MAINFSM_MEMWAIT_EN defined, MemReady SHALL be present and wait states SHALL apply:
  - FETCH, MEMREAD and MEMWRITE SHALL hold their state while MemReady=0.
  - MemW SHALL stay high throughout a held MEMWRITE.
  - In FETCH, IRWrite and NextPC SHALL equal MemReady.
  - A stall SHALL last an unbounded number of cycles.
- REQ-017: Without MAINFSM_MEMWAIT_EN, the MemReady port SHALL be absent and behaviour SHALL be exactly REQ-004 to REQ-011.

Structure
- REQ-018: A shared package SHALL hold:
  - the 4-bit state encodings, FETCH=0 through UNKNOWN=10;
  - the ALUSrcA, ALUSrcB and ResultSrc constants;
  - the Op class constants.
- REQ-019: Output decoding SHALL be a single combinational sub-module, mainfsm_outdec, with state in and the control bundle out; the state register and next-state logic SHALL remain in mainfsm.

Verification
- REQ-020: The bench SHALL cover these directed scenarios:
  - Release reset with Op=00, Funct=000000 → States FETCH, DECODE, EXECUTER, ALUWB, FETCH; RegW=1 only in ALUWB.
  - Op=01, Funct=000001 → FETCH, DECODE, MEMADR, MEMREAD, MEMWB; ResultSrc=01 and RegW=1 in MEMWB; AdrSrc=1 in MEMREAD.
  - Op=01, Funct=000000 → MEMWRITE reached in cycle 4 with MemW=1 for exactly 1 cycle, then FETCH.
  - Op=10 → BRANCH with Branch=1, ALUSrcA=10, ALUSrcB=01, then FETCH; Op=11 → UNKNOWN with all outputs 0.
  - Assert reset=0 while in MEMWRITE → State=FETCH immediately, MemW=0 in the same cycle, no strobe until release.
  - With MAINFSM_MEMWAIT_EN: MemReady=0 for 3 cycles in FETCH → State stays FETCH, IRWrite=0; MemReady=1 → IRWrite=1 for 1 cycle, then DECODE.
